dmem_hs: RTL and testbench
==========================

Name: dmem_hs

Overview:
Parametrised successor to the single-cycle data memory used by the data path. It adds a valid/ready request/response handshake, a configurable number of wait states and byte-lane (LDRB/STRB) access. It also detects misaligned word accesses. It sits between the data path's load/store unit and on-chip RAM, and lets the core be tested against multi-cycle memory.

Parameters:
DATA_W, 32, word width in bits; multiple of 8, >= 16; LANE_BITS = log2(DATA_W/8)
DEPTH, 64, number of words; power of 2; IDX_W = log2(DEPTH)
ADDR_W, 32, byte-address width; >= IDX_W + LANE_BITS
WAIT_STATES, 1, extra cycles before a response; 0..15

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  block can accept a request
req_we  input  1  1 = store, 0 = load
req_byte  input  1  1 = byte access, 0 = word access
req_addr  input  ADDR_W  byte address
req_wdata  input  DATA_W  store data; byte stores use bits [7:0]
resp_valid  output  1  response present
resp_ready  input  1  consumer accepts the response
resp_rdata  output  DATA_W  load data; 0 for stores and for faults
resp_fault  output  1  access faulted; no write was performed

Behaviour:
- Word index = req_addr[LANE_BITS +: IDX_W]. Lane = req_addr[LANE_BITS-1:0].
- FSM states are IDLE, WAIT and RESP. Reset enters IDLE.
- req_ready = (state == IDLE) & ~reset. It is 0 in WAIT and RESP; there is only one outstanding transaction.
- On accept (req_valid & req_ready at a rising edge), latch we, byte, addr and wdata.
  - If WAIT_STATES == 0, go to RESP.
  - Otherwise go to WAIT with cnt = WAIT_STATES.
- WAIT: cnt decrements each cycle. On the edge where cnt == 1, go to RESP.
- resp_valid first rises exactly WAIT_STATES+1 cycles after the accept edge.
- Commit point is the edge entering RESP. At that edge:
  - Stores are written to RAM.
  - resp_rdata and resp_fault are registered.
  - A load reads RAM contents that include every previously completed store.
- Word store writes all lanes. Byte store writes only the selected lane from wdata[7:0]; other lanes are unchanged.
- Word load returns the full word. Byte load returns the selected lane zero-extended.
- Fault: word access with lane != 0.
  - resp_fault = 1 and resp_rdata = 0.
  - A faulted store does not modify RAM.
- RESP: resp_valid = 1. resp_rdata and resp_fault are held stable until resp_valid & resp_ready. On that handshake, go to IDLE.
- A new request is accepted no earlier than the cycle after the response handshake.
- Reset values: resp_valid 0, resp_rdata 0, resp_fault 0, state IDLE, cnt 0. req_ready is 0 while reset is high.
- RAM contents are not reset.
- Reset mid-transaction (WAIT or RESP) abandons it immediately.
  - A store not yet at its commit edge is not written.
  - A store already committed stays written.
- Address bits above the index field are ignored (modulo DEPTH aliasing) unless the optional feature below is enabled.
- req_* inputs are ignored outside an accept edge.

Optional Feature:
DMEM_BOUNDS_CHECK_EN
- Defined: any set req_addr bit at or above position LANE_BITS+IDX_W is a fault. The response has resp_fault = 1, resp_rdata = 0, and no write. Latency is unchanged.
- Undefined: those bits are ignored and the address wraps modulo DEPTH words.

Test Plan:
1. Reset; word store 0xDEADBEEF @0x08 (WAIT_STATES=1, resp_ready=1) -> resp_valid 2 cycles after accept, fault 0. Then word load @0x08 -> rdata 0xDEADBEEF.
2. Byte store 0xA5 @0x09 -> word load @0x08 = 0xDEADA5EF. Byte load @0x0B -> 0x000000DE.
3. Word load @0x06 -> fault 1, rdata 0. Word store 0x11111111 @0x0A -> fault 1; word load @0x08 still 0xDEADA5EF.
4. Hold resp_ready=0 for 5 cycles in RESP while req_valid=1 -> resp_valid, rdata and fault stable; req_ready 0; no second accept. Second request accepted the cycle after resp_ready rises.
5. Store 0x00001234 @0x10 (old value 0xCAFEF00D), assert reset during WAIT -> resp_valid 0 immediately. After release, load @0x10 = 0xCAFEF00D.
6. Store 0x55 word @0x100 (DEPTH=64, DATA_W=32):
   - Without macro -> aliases to 0x00; load @0x00 = 0x00000055.
   - With DMEM_BOUNDS_CHECK_EN -> fault 1; @0x00 unchanged.
   - Repeat with WAIT_STATES=0 -> resp_valid one cycle after accept.

Source files
------------

// File: rtl/dmem_hs.sv
// dmem_hs: word-addressed on-chip data memory behind a valid/ready
// request/response handshake, with programmable wait states, byte-lane
// (LDRB/STRB) access and misaligned-word fault detection.
//
// Optional build macro: DMEM_BOUNDS_CHECK_EN
//   defined   -> any set address bit above the index field faults the access
//   undefined -> those bits are ignored (addresses alias modulo DEPTH words)
//
// Ports
//   clk, reset              rising-edge clock, async active-high reset
//   req_valid / req_ready   request handshake (one transaction outstanding)
//   req_we, req_byte        store/load, byte/word
//   req_addr, req_wdata     byte address, store data (byte stores use [7:0])
//   resp_valid / resp_ready response handshake
//   resp_rdata, resp_fault  load data (0 for stores/faults), fault flag
module dmem_hs #(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 64,
  parameter int ADDR_W      = 32,
  parameter int WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic              req_byte,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_fault
);

  localparam int LANE_BITS = $clog2(DATA_W / 8);
  localparam int IDX_W     = $clog2(DEPTH);
  localparam int HI        = LANE_BITS + IDX_W;
  localparam int CNT_W     = 4;

`ifdef DMEM_BOUNDS_CHECK_EN
  localparam bit BOUNDS_EN = 1'b1;
`else
  localparam bit BOUNDS_EN = 1'b0;
`endif

  typedef struct packed {
    logic              we;
    logic              is_byte;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t               state, state_nx;
  logic [CNT_W-1:0]     cnt;
  req_t                 req_q, live, op;
  logic                 accept, commit, fault, misalign, oob;
  logic [IDX_W-1:0]     idx;
  logic [LANE_BITS-1:0] lane;
  logic [DATA_W-1:0]    rd_word, load_data;
  logic [7:0]           rd_lane;

  logic [DATA_W-1:0] mem [DEPTH];

  assign accept = req_valid & req_ready;

  // With zero wait states the commit edge is the accept edge itself, so the
  // operation must come straight from the ports; otherwise from the latch.
  always_comb begin
    live.we      = req_we;
    live.is_byte = req_byte;
    live.addr    = req_addr;
    live.wdata   = req_wdata;
    op = (state == S_IDLE) ? live : req_q;
  end

  assign idx      = op.addr[LANE_BITS +: IDX_W];
  assign lane     = op.addr[LANE_BITS-1:0];
  assign misalign = ~op.is_byte & (lane != '0);
  assign oob      = |(op.addr >> HI);
  assign fault    = misalign | (BOUNDS_EN & oob);

  assign commit = ~reset &
                  ((state == S_IDLE && accept && WAIT_STATES == 0) ||
                   (state == S_WAIT && cnt == CNT_W'(1)));

  assign rd_word   = mem[idx];
  assign rd_lane   = rd_word[{lane, 3'b000} +: 8];
  assign load_data = op.is_byte ? {{(DATA_W-8){1'b0}}, rd_lane} : rd_word;

  // RAM has no reset; a write happens only on the commit edge of a
  // non-faulting store.
  always_ff @(posedge clk) begin
    if (commit && op.we && !fault) begin
      if (op.is_byte) mem[idx][{lane, 3'b000} +: 8] <= op.wdata[7:0];
      else            mem[idx] <= op.wdata;
    end
  end

  // FSM: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  // FSM: next state
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (accept) state_nx = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
      S_WAIT: if (cnt == CNT_W'(1)) state_nx = S_RESP;
      S_RESP: if (resp_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    req_ready  = (state == S_IDLE) & ~reset;
    resp_valid = (state == S_RESP);
  end

  // Request latch, wait counter and registered response
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_q      <= '0;
      cnt        <= '0;
      resp_rdata <= '0;
      resp_fault <= 1'b0;
    end else begin
      if (accept) begin
        req_q <= live;
        cnt   <= CNT_W'(WAIT_STATES);
      end else if (state == S_WAIT) begin
        cnt <= cnt - 1'b1;
      end
      if (commit) begin
        resp_rdata <= (fault | op.we) ? '0 : load_data;
        resp_fault <= fault;
      end
    end
  end

endmodule

// File: tb/tb_dmem_hs.sv
module tb_dmem_hs;

`ifdef DMEM_BOUNDS_CHECK_EN
  localparam bit BC = 1'b1;
`else
  localparam bit BC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        sel;
  logic        req_valid, req_we, req_byte, resp_ready;
  logic [31:0] req_addr, req_wdata;

  logic        rdy_a, vld_a, flt_a, rdy_b, vld_b, flt_b;
  logic [31:0] rd_a, rd_b;
  logic        m_ready, m_valid, m_fault;
  logic [31:0] m_rdata;

  always #5 clk = ~clk;

  // u_a: one wait state; u_b: zero wait states. sel routes requests.
  dmem_hs #(.DATA_W(32), .DEPTH(64), .ADDR_W(32), .WAIT_STATES(1)) u_a (
    .clk(clk), .reset(reset), .req_valid(req_valid & ~sel), .req_ready(rdy_a),
    .req_we(req_we), .req_byte(req_byte), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(vld_a), .resp_ready(resp_ready), .resp_rdata(rd_a), .resp_fault(flt_a));

  dmem_hs #(.DATA_W(32), .DEPTH(64), .ADDR_W(32), .WAIT_STATES(0)) u_b (
    .clk(clk), .reset(reset), .req_valid(req_valid & sel), .req_ready(rdy_b),
    .req_we(req_we), .req_byte(req_byte), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(vld_b), .resp_ready(resp_ready), .resp_rdata(rd_b), .resp_fault(flt_b));

  assign m_ready = sel ? rdy_b : rdy_a;
  assign m_valid = sel ? vld_b : vld_a;
  assign m_rdata = sel ? rd_b  : rd_a;
  assign m_fault = sel ? flt_b : flt_a;

  typedef struct {
    logic        sel, we, byt;
    logic [31:0] addr, wdata, rdata;
    logic        fault;
  } vec_t;

  vec_t v[$];
  int   n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic add(input logic s, we, byt, input logic [31:0] addr, wdata, rdata, input logic f);
    vec_t t;
    t.sel = s; t.we = we; t.byt = byt; t.addr = addr; t.wdata = wdata;
    t.rdata = rdata; t.fault = f;
    v.push_back(t);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!m_ready && n < 40) begin @(negedge clk); n++; end
    if (!m_ready) begin
      n_chk++; n_fail++;
      $display("FAIL req_ready timeout: got 0 expected 1");
    end
  endtask

  // Counts negedges from the accept negedge until resp_valid is seen.
  task automatic wait_resp(input int start, output int lat);
    lat = start;
    while (!m_valid && lat < 40) begin @(negedge clk); lat++; end
    if (!m_valid) begin
      n_chk++; n_fail++;
      $display("FAIL resp_valid timeout: got 0 expected 1");
    end
  endtask

  task automatic xact(input vec_t t, input int i);
    int lat;
    @(negedge clk);
    sel = t.sel; req_valid = 1'b1; req_we = t.we; req_byte = t.byt;
    req_addr = t.addr; req_wdata = t.wdata; resp_ready = 1'b1;
    wait_ready();
    wait_resp(0, lat);
    req_valid = 1'b0;
    chk($sformatf("v%0d latency", i), lat, t.sel ? 32'd1 : 32'd2);
    chk($sformatf("v%0d rdata", i), m_rdata, t.rdata);
    chk($sformatf("v%0d fault", i), {31'd0, m_fault}, {31'd0, t.fault});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    vec_t t;
    reset = 1'b1; sel = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_byte = 1'b0;
    req_addr = '0; req_wdata = '0; resp_ready = 1'b1;

    // sel we byt addr wdata expected_rdata expected_fault
    add(0, 1, 0, 32'h08,  32'hDEADBEEF, 32'h0,        0);
    add(0, 0, 0, 32'h08,  32'h0,        32'hDEADBEEF, 0);
    add(0, 1, 1, 32'h09,  32'hFFFFFFA5, 32'h0,        0);
    add(0, 0, 0, 32'h08,  32'h0,        32'hDEADA5EF, 0);
    add(0, 0, 1, 32'h0B,  32'h0,        32'h000000DE, 0);
    add(0, 0, 1, 32'h08,  32'h0,        32'h000000EF, 0);
    add(0, 0, 0, 32'h06,  32'h0,        32'h0,        1);
    add(0, 1, 0, 32'h0A,  32'h11111111, 32'h0,        1);
    add(0, 0, 0, 32'h08,  32'h0,        32'hDEADA5EF, 0);
    add(0, 1, 0, 32'h10,  32'hCAFEF00D, 32'h0,        0);
    add(0, 0, 0, 32'h10,  32'h0,        32'hCAFEF00D, 0);
    add(0, 1, 0, 32'h00,  32'h0,        32'h0,        0);
    add(0, 1, 0, 32'h100, 32'h55,       32'h0,        BC);
    add(0, 0, 0, 32'h00,  32'h0,        BC ? 32'h0 : 32'h55, 0);
    add(1, 1, 0, 32'h20,  32'h12345678, 32'h0,        0);
    add(1, 0, 1, 32'h21,  32'h0,        32'h56,       0);
    add(1, 0, 0, 32'h22,  32'h0,        32'h0,        1);
    add(1, 1, 0, 32'h00,  32'h0,        32'h0,        0);
    add(1, 1, 0, 32'h100, 32'h55,       32'h0,        BC);
    add(1, 0, 0, 32'h00,  32'h0,        BC ? 32'h0 : 32'h55, 0);
    add(1, 0, 1, 32'h101, 32'h0,        32'h0,        BC);
    add(1, 1, 1, 32'h103, 32'h000000C3, 32'h0,        BC);
    add(1, 0, 0, 32'h00,  32'h0,        BC ? 32'h0 : 32'hC3000055, 0);

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst req_ready", {31'd0, m_ready}, 32'd0);
    chk("rst resp_valid", {31'd0, m_valid}, 32'd0);
    chk("rst resp_rdata", m_rdata, 32'd0);
    chk("rst resp_fault", {31'd0, m_fault}, 32'd0);
    reset = 1'b0;
    #1;
    chk("post-rst req_ready", {31'd0, m_ready}, 32'd1);

    foreach (v[i]) xact(v[i], i);

    // Backpressure: response held, no second accept, next request taken
    // the cycle after the handshake. Request fields change while the first
    // transaction is in flight and must not affect it.
    @(negedge clk);
    sel = 1'b0; req_valid = 1'b1; req_we = 1'b0; req_byte = 1'b0;
    req_addr = 32'h08; resp_ready = 1'b0;
    wait_ready();
    @(negedge clk);
    req_byte = 1'b1;
    wait_resp(1, lat);
    chk("bp latency", lat, 32'd2);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp%0d resp_valid", k), {31'd0, m_valid}, 32'd1);
      chk($sformatf("bp%0d rdata", k), m_rdata, 32'hDEADA5EF);
      chk($sformatf("bp%0d fault", k), {31'd0, m_fault}, 32'd0);
      chk($sformatf("bp%0d req_ready", k), {31'd0, m_ready}, 32'd0);
      @(negedge clk);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    chk("bp idle req_ready", {31'd0, m_ready}, 32'd1);
    chk("bp idle resp_valid", {31'd0, m_valid}, 32'd0);
    @(negedge clk);
    chk("bp 2nd accepted", {31'd0, m_ready}, 32'd0);
    req_valid = 1'b0;
    wait_resp(1, lat);
    chk("bp 2nd latency", lat, 32'd2);
    chk("bp 2nd rdata", m_rdata, 32'h000000EF);

    // Reset during WAIT: store abandoned before its commit edge
    @(negedge clk);
    sel = 1'b0; req_valid = 1'b1; req_we = 1'b1; req_byte = 1'b0;
    req_addr = 32'h10; req_wdata = 32'h00001234; resp_ready = 1'b1;
    wait_ready();
    @(negedge clk);
    req_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("rstw resp_valid", {31'd0, m_valid}, 32'd0);
    chk("rstw req_ready", {31'd0, m_ready}, 32'd0);
    @(negedge clk);
    chk("rstw held resp_valid", {31'd0, m_valid}, 32'd0);
    reset = 1'b0;
    t.sel = 0; t.we = 0; t.byt = 0; t.addr = 32'h10; t.wdata = 0;
    t.rdata = 32'hCAFEF00D; t.fault = 0;
    xact(t, 100);

    // Reset during RESP: committed store survives, response dropped
    @(negedge clk);
    sel = 1'b0; req_valid = 1'b1; req_we = 1'b1; req_byte = 1'b0;
    req_addr = 32'h14; req_wdata = 32'hABCD0000; resp_ready = 1'b0;
    wait_ready();
    @(negedge clk);
    req_valid = 1'b0;
    wait_resp(1, lat);
    chk("rstr resp_valid before", {31'd0, m_valid}, 32'd1);
    reset = 1'b1;
    #1;
    chk("rstr resp_valid", {31'd0, m_valid}, 32'd0);
    chk("rstr resp_rdata", m_rdata, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    t.addr = 32'h14; t.rdata = 32'hABCD0000;
    xact(t, 101);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
